// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: datapath width,
// FSM state encoding, default reset PC / increment, and the helper that
// produces the PC alignment mask for a given increment.
package pc_sequencer_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t       DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEFAULT_INC      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Bits of a PC that must be zero for a fetch of size `inc` (inc is a power of two).
  function automatic word_t low_mask(input int unsigned inc);
    return word_t'(inc - 1);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of everything the PC sequencer exchanges with instruction memory,
// decode and execute. `master` is the sequencer's view, `slave` is the
// view of the surrounding pipeline/memory.
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  // Pipeline control
  logic  stall;
  logic  redirect_valid;
  word_t redirect_pc;

  // Instruction memory handshake
  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_rdata;

  // Towards decode / PC buffer
  logic  instr_valid;
  word_t instr;
  word_t instr_pc;
  word_t pc_next;
  logic  misalign;

  modport master (
    input  stall, redirect_valid, redirect_pc, imem_ack, imem_rdata,
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc_next, misalign
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_ack, imem_rdata,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc_next, misalign
  );

endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns the PC, issues one instruction fetch at a
// time over a req/ack handshake, applies redirects from execute and holds
// the fetched instruction while decode stalls. Every output is a register.
// INC must be a power of two no smaller than 4.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter word_t       RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned INC      = DEFAULT_INC
) (
  input logic            clk,
  input logic            rst,
  pc_sequencer_if.master bus
);

  localparam word_t LOW_MASK = low_mask(INC);
  localparam word_t INC_W    = word_t'(INC);

  state_e state_q, state_d;

  word_t pc_q, pc_d;
  word_t instr_q, instr_d;
  word_t instr_pc_q, instr_pc_d;
  logic  valid_q, valid_d;
  logic  misalign_q, misalign_d;
  logic  req_q, req_d;
  word_t addr_q, addr_d;

  word_t redirect_target;
  logic  redirect_misaligned;
  word_t pc_inc;

  assign redirect_target     = bus.redirect_pc & ~LOW_MASK;
  assign redirect_misaligned = |(bus.redirect_pc & LOW_MASK);
  assign pc_inc              = pc_q + INC_W;  // wraps modulo 2^32 by width

  // State register.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a redirect outranks the ack/stall decisions.
  // NOTE: each combinational output gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.redirect_valid)
          // With ack in hand the old request is finished; otherwise it must drain.
          state_d = bus.imem_ack ? ST_FETCH : ST_DRAIN;
        else if (bus.imem_ack)
          state_d = bus.stall ? ST_HOLD : ST_FETCH;
      end
      // The outstanding request completes on ack; a redirect arriving in the
      // same cycle only retargets pc, there is nothing left to drain.
      ST_DRAIN: if (bus.imem_ack) state_d = ST_FETCH;
      ST_HOLD:  if (bus.redirect_valid || !bus.stall) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the PC, the instruction buffer and the memory request.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    misalign_d = 1'b0;

    if (bus.redirect_valid) begin
      pc_d       = redirect_target;
      valid_d    = 1'b0;
      misalign_d = redirect_misaligned;
    end else if (state_q == ST_FETCH) begin
      if (bus.imem_ack) begin
        instr_d    = bus.imem_rdata;
        instr_pc_d = pc_q;
        valid_d    = 1'b1;
        pc_d       = pc_inc;
      end else if (!bus.stall) begin
        // Decode consumed the previous instruction and nothing new arrived.
        valid_d = 1'b0;
      end
    end

    // Request follows the state we are entering; a drain keeps the old address.
    req_d  = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
    addr_d = (state_d == ST_DRAIN) ? addr_q : pc_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.pc_next     = pc_q;
  assign bus.misalign    = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with RESET_PC=0x100, INC=4: a table of
// per-cycle inputs and hand-computed post-edge outputs, followed by an
// asynchronous reset asserted in the middle of a drain.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  typedef struct {
    logic  stall;
    logic  rv;
    word_t rpc;
    logic  ack;
    word_t rdata;
    logic  e_req;
    word_t e_addr;
    logic  e_valid;
    word_t e_instr;
    word_t e_ipc;
    word_t e_pcn;
    logic  e_mis;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  pc_sequencer_if bus();

  pc_sequencer #(.RESET_PC(32'h0000_0100), .INC(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic req, input word_t addr,
                               input logic valid, input word_t instr, input word_t ipc,
                               input word_t pcn, input logic mis);
    check({tag, " imem_req"},    word_t'(bus.imem_req),    word_t'(req));
    check({tag, " imem_addr"},   bus.imem_addr,            addr);
    check({tag, " instr_valid"}, word_t'(bus.instr_valid), word_t'(valid));
    check({tag, " instr"},       bus.instr,                instr);
    check({tag, " instr_pc"},    bus.instr_pc,             ipc);
    check({tag, " pc_next"},     bus.pc_next,              pcn);
    check({tag, " misalign"},    word_t'(bus.misalign),    word_t'(mis));
  endtask

  task automatic drive(input logic stall, input logic rv, input word_t rpc,
                       input logic ack, input word_t rdata);
    bus.stall          = stall;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.imem_ack       = ack;
    bus.imem_rdata     = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic stall, input logic rv, input word_t rpc,
                              input logic ack, input word_t rdata,
                              input logic req, input word_t addr, input logic valid,
                              input word_t instr, input word_t ipc, input word_t pcn,
                              input logic mis);
    vec_t v;
    v.stall = stall; v.rv = rv; v.rpc = rpc; v.ack = ack; v.rdata = rdata;
    v.e_req = req; v.e_addr = addr; v.e_valid = valid; v.e_instr = instr;
    v.e_ipc = ipc; v.e_pcn = pcn; v.e_mis = mis;
    return v;
  endfunction

  initial begin
    //                stall rv rpc           ack rdata          req addr          vld instr          ipc           pcn           mis
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0100, 0, 32'h0,          32'h0,          32'h0000_0100, 0)); // first request
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'hAAAA_0100,  1, 32'h0000_0104, 1, 32'hAAAA_0100,  32'h0000_0100,  32'h0000_0104, 0));
    vecs.push_back(mk(1, 0, 32'h0,          1, 32'hAAAA_0104,  0, 32'h0000_0108, 1, 32'hAAAA_0104,  32'h0000_0104,  32'h0000_0108, 0)); // ack+stall -> HOLD
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,          0, 32'h0000_0108, 1, 32'hAAAA_0104,  32'h0000_0104,  32'h0000_0108, 0));
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,          0, 32'h0000_0108, 1, 32'hAAAA_0104,  32'h0000_0104,  32'h0000_0108, 0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0108, 1, 32'hAAAA_0104,  32'h0000_0104,  32'h0000_0108, 0)); // release
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0108, 0, 32'hAAAA_0104,  32'h0000_0104,  32'h0000_0108, 0)); // consumed
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'hAAAA_0108,  1, 32'h0000_010C, 1, 32'hAAAA_0108,  32'h0000_0108,  32'h0000_010C, 0));
    vecs.push_back(mk(0, 1, 32'h0000_2000,  0, 32'h0,          1, 32'h0000_010C, 0, 32'hAAAA_0108,  32'h0000_0108,  32'h0000_2000, 0)); // -> DRAIN
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_010C, 0, 32'hAAAA_0108,  32'h0000_0108,  32'h0000_2000, 0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_010C, 0, 32'hAAAA_0108,  32'h0000_0108,  32'h0000_2000, 0));
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'hDEAD_010C,  1, 32'h0000_2000, 0, 32'hAAAA_0108,  32'h0000_0108,  32'h0000_2000, 0)); // drain ack dropped
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'hBBBB_2000,  1, 32'h0000_2004, 1, 32'hBBBB_2000,  32'h0000_2000,  32'h0000_2004, 0));
    vecs.push_back(mk(0, 1, 32'h0000_2002,  1, 32'hDEAD_2004,  1, 32'h0000_2000, 0, 32'hBBBB_2000,  32'h0000_2000,  32'h0000_2000, 1)); // redirect+ack, misaligned
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,          1, 32'h0000_2000, 0, 32'hBBBB_2000,  32'h0000_2000,  32'h0000_2000, 0)); // misalign one cycle only
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFC,  0, 32'h0,          1, 32'h0000_2000, 0, 32'hBBBB_2000,  32'h0000_2000,  32'hFFFF_FFFC, 0));
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'hDEAD_2000,  1, 32'hFFFF_FFFC, 0, 32'hBBBB_2000,  32'h0000_2000,  32'hFFFF_FFFC, 0));
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'hCCCC_FFFC,  1, 32'h0000_0000, 1, 32'hCCCC_FFFC,  32'hFFFF_FFFC,  32'h0000_0000, 0)); // wrap
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'hCCCC_0000,  1, 32'h0000_0004, 1, 32'hCCCC_0000,  32'h0000_0000,  32'h0000_0004, 0));
    vecs.push_back(mk(1, 0, 32'h0,          1, 32'hCCCC_0004,  0, 32'h0000_0008, 1, 32'hCCCC_0004,  32'h0000_0004,  32'h0000_0008, 0));
    vecs.push_back(mk(1, 1, 32'h0000_0400,  0, 32'h0,          1, 32'h0000_0400, 0, 32'hCCCC_0004,  32'h0000_0004,  32'h0000_0400, 0)); // redirect from HOLD

    drive(0, 0, '0, 0, '0);

    // Power-on reset values while rst is held.
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, 32'h0000_0100, 1'b0, 32'h0, 32'h0, 32'h0000_0100, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].ack, vecs[i].rdata);
      tick();
      check_outputs($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                    vecs[i].e_instr, vecs[i].e_ipc, vecs[i].e_pcn, vecs[i].e_mis);
    end

    // Enter DRAIN, then assert reset between clock edges.
    drive(0, 1, 32'h0000_0800, 0, '0);
    tick();
    check("drain entry addr", bus.imem_addr, 32'h0000_0400);
    drive(0, 0, '0, 0, '0);
    #2;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 1'b0, 32'h0000_0100, 1'b0, 32'h0, 32'h0, 32'h0000_0100, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("idle after release req", word_t'(bus.imem_req), 32'h0);

    // Restart: requests at 0x100, 0x104, 0x108 with memory acking every request.
    tick();
    check("restart addr0", bus.imem_addr, 32'h0000_0100);
    check("restart req0", word_t'(bus.imem_req), 32'h1);
    drive(0, 0, '0, 1, 32'h1111_0100);
    tick();
    check("restart valid", word_t'(bus.instr_valid), 32'h1);
    check("restart ipc", bus.instr_pc, 32'h0000_0100);
    check("restart instr", bus.instr, 32'h1111_0100);
    check("restart addr1", bus.imem_addr, 32'h0000_0104);
    drive(0, 0, '0, 1, 32'h1111_0104);
    tick();
    check("restart addr2", bus.imem_addr, 32'h0000_0108);
    check("restart ipc1", bus.instr_pc, 32'h0000_0104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage controller that owns the program counter and sequences instruction fetches from instruction memory. Issues one request at a time over a req/ack handshake, advances the PC by a fixed increment on each completed fetch, and applies branch/jump redirects from execute. Holds the fetched instruction while decode stalls. Its `pc_next` output drives the PC buffer register in the fetch path.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `INC`, default 4: PC increment per completed fetch; must be a power of two ≥ 4.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: decode cannot accept; hold the current instruction.
- `redirect_valid` in 1: branch/jump taken this cycle.
- `redirect_pc` in 32: redirect target.
- `imem_req` out 1: fetch request, held until ack.
- `imem_addr` out 32: fetch address; stable while `imem_req`=1.
- `imem_ack` in 1: fetch complete; `imem_rdata` valid this cycle.
- `imem_rdata` in 32: fetched instruction word.
- `instr_valid` out 1: `instr`/`instr_pc` hold a live instruction.
- `instr` out 32: registered instruction.
- `instr_pc` out 32: address of `instr`.
- `pc_next` out 32: current PC (next address to fetch), to PC buffer.
- `misalign` out 1: one-cycle pulse, redirect target had nonzero low bits.

## Operation
- States: IDLE, FETCH, DRAIN, HOLD.
- Reset, any state: state=IDLE; pc=`RESET_PC`; `imem_req`=0; `instr_valid`=0; `instr`=0; `instr_pc`=0; `misalign`=0; `imem_addr`=`RESET_PC`.
- IDLE: no request; next cycle → FETCH.
- FETCH: `imem_req`=1, `imem_addr`=pc. On `imem_ack`: `instr`←`imem_rdata`, `instr_pc`←pc, `instr_valid`←1, pc←pc+`INC`. Next state HOLD if `stall`=1 in the ack cycle, else FETCH (back-to-back fetches).
- HOLD: `imem_req`=0; `instr`/`instr_pc`/`instr_valid` frozen. When `stall`=0 → FETCH.
- In FETCH without ack: when `stall`=0 and no ack, `instr_valid` clears the cycle after decode consumes (valid=1, stall=0).
- Redirect (priority over everything except reset): pc←`redirect_pc` with low log2(`INC`) bits cleared; `instr_valid`←0; `misalign` pulses if any cleared bit was 1.
  - From FETCH with no ack in the same cycle: request outstanding → DRAIN.
  - From FETCH with ack in the same cycle: ack data discarded, pc does not increment → FETCH.
  - From HOLD or IDLE: → FETCH.
  - From DRAIN: updates pc target, stays DRAIN.
- DRAIN: `imem_req`=1 at the old address until `imem_ack`; ack data discarded; → FETCH at new pc.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000; no flag.

## Timing
- Rising-edge registered outputs; no combinational path from inputs to outputs except none (all outputs registered).
- Fetch-to-valid latency: `instr_valid` rises the cycle after `imem_ack`.
- First request is issued 1 cycle after reset release (IDLE lasts one cycle).
- Sustained throughput: one instruction per cycle when memory acks on the request cycle and `stall`=0.
- `imem_addr` must not change while `imem_req`=1 and ack not yet seen.
- Redirect-to-new-request: 1 cycle (or after the drain ack).

## Structure
- Shared package: state encoding (IDLE/FETCH/DRAIN/HOLD, 2 bits), `RESET_PC` default, and instruction/address width constant (32).
- Single module, no sub-modules; the PC increment is one adder inside the block.

## Test plan
- Reset with `RESET_PC`=32'h100, memory acks every request: requests at 0x100, 0x104, 0x108; `instr_valid` first high 1 cycle after the first ack; `instr_pc`=0x100.
- Stall in ack cycle at 0x104: HOLD; `instr`/`instr_pc`=0x104 stable, no `imem_req`; release stall → next request at 0x108.
- Redirect to 0x2000 while request at 0x10C awaits ack (ack 3 cycles later): DRAIN holds addr 0x10C; ack data dropped; next request 0x2000; no `instr_valid` for 0x10C.
- Redirect and ack same cycle: ack data dropped, next request at target; redirect to 0x2002 → fetch 0x2000, `misalign` pulses one cycle.
- PC at 0xFFFF_FFFC with ack: next request 0x0000_0000.
- Assert `rst` mid-DRAIN: all outputs reset immediately (async); after release, fetch restarts at `RESET_PC`.
